boot_loader: RTL and testbench

//  Streams a program image into instruction RAM word-by-word, then releases the processor from reset.

---
 rtl/boot_loader.sv | 148 ++++++++++++++
 tb/tb_boot_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a checksummed program image into imem, then releases processor reset
//
// Purpose:
//   Accepts an image made of a length word N, then N instruction words, then a
//   checksum word (the mod-2^DATA_WIDTH sum of the N words). Each instruction
//   word is written into imem one cycle after it is accepted. When the checksum
//   matches, proc_reset is held for RESET_HOLD more cycles and then released.
//   A length overflow or a checksum mismatch parks the loader in an error state.
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   synchronous, active-high; restarts the loader
//   in_valid     in   input word valid
//   in_data      in   input word
//   in_ready     out  word accepted when in_valid & in_ready
//   mem_address  out  imem write address
//   mem_data     out  imem write data
//   mem_wren     out  imem write enable, one pulse per instruction word
//   proc_reset   out  processor/regfile reset, high until the image is verified
//   done         out  image loaded and verified (sticky until reset)
//   error        out  length overflow or checksum mismatch (sticky until reset)
//   word_count   out  instruction words accepted so far
module boot_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  output logic                  proc_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_HEADER,
    S_LOAD,
    S_CHECK,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  // Largest legal image length, 2^ADDR_WIDTH, expressed at input-word width.
  localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic [ADDR_WIDTH:0]   n_len;
  logic [DATA_WIDTH-1:0] acc;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [ADDR_WIDTH:0]   wc_next;
  logic                  accept;

  // Gated by reset so no word is ever taken in a reset cycle, whatever state we were in.
  assign in_ready   = !reset && (state == S_HEADER || state == S_LOAD || state == S_CHECK);
  assign accept     = in_valid && in_ready;
  assign wc_next    = word_count + (ADDR_WIDTH + 1)'(1);
  assign done       = (state == S_RUN);
  assign error      = (state == S_ERROR);
  assign proc_reset = !done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_HEADER;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_HEADER: begin
        if (accept) begin
          if (in_data > MAX_LEN) begin
            state_next = S_ERROR;
          end else if (in_data == '0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept && wc_next == n_len) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_next = (in_data == acc) ? S_HOLD : S_ERROR;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_next = S_RUN;
        end
      end
      default: state_next = state;
    endcase
  end

  // Datapath: the write for a LOAD accept is registered here, which is what
  // makes the last word's write land in the first CHECK cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      n_len       <= '0;
      acc         <= '0;
      hold_cnt    <= '0;
      word_count  <= '0;
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        S_HEADER: begin
          if (accept) begin
            n_len <= in_data[ADDR_WIDTH:0];
          end
        end
        S_LOAD: begin
          if (accept) begin
            acc         <= acc + in_data;
            word_count  <= wc_next;
            mem_wren    <= 1'b1;
            mem_address <= word_count[ADDR_WIDTH-1:0];
            mem_data    <= in_data;
          end
        end
        S_HOLD: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - self-checking bench for boot_loader with an image-level reference model
module tb_boot_loader;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int HOLD = 4;
  localparam int MAXN = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_wren;
  logic          proc_reset;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  boot_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_HOLD(HOLD)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .proc_reset  (proc_reset),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Cycle-level invariants and write-pulse counting.
  always @(negedge clock) begin
    check("proc_reset_is_not_done", proc_reset, !done);
    check("done_and_error_exclusive", done && error, 1'b0);
    if (mem_wren) wr_count++;
  end

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("rst_in_ready_low", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_proc_reset", proc_reset, 1'b1);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_addr", mem_address, 0);
    check("rst_data", mem_data, 0);
    check("rst_word_count", word_count, 0);
  endtask

  // Starts and ends just after a falling edge; checks the 1-cycle write latency.
  task automatic send(input logic [DW-1:0] w, input bit is_data, input int idx, input int max_gap);
    int n;
    repeat ($urandom_range(max_gap, 0)) @(negedge clock);
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
    if (is_data) begin
      check("wr_en", mem_wren, 1'b1);
      check("wr_addr", mem_address, idx);
      check("wr_data", mem_data, w);
    end
  endtask

  // Reference model: outcome follows from N, the word list and the checksum alone.
  task automatic run_image(input int n, input logic [DW-1:0] words[$],
                           input logic [DW-1:0] cks, input int max_gap);
    logic [DW-1:0] sum;
    bit overflow, exp_err;
    int base;
    sum = '0;
    foreach (words[i]) sum = sum + words[i];
    overflow = (n > MAXN);
    exp_err  = overflow || (cks != sum);

    do_reset();
    base = wr_count;
    send(DW'(n), 1'b0, 0, max_gap);
    if (overflow) begin
      check("ovf_error", error, 1'b1);
      check("ovf_in_ready", in_ready, 1'b0);
      check("ovf_word_count", word_count, 0);
      @(negedge clock);
      check("ovf_no_writes", wr_count - base, 0);
      return;
    end
    for (int i = 0; i < n; i++) send(words[i], 1'b1, i, max_gap);
    send(cks, 1'b0, 0, max_gap);
    check("img_write_count", wr_count - base, n);
    check("img_word_count", word_count, n);
    if (exp_err) begin
      check("bad_error", error, 1'b1);
      check("bad_done", done, 1'b0);
      check("bad_proc_reset", proc_reset, 1'b1);
      check("bad_in_ready", in_ready, 1'b0);
    end else begin
      check("hold_done_low", done, 1'b0);
      for (int c = 1; c < HOLD; c++) begin
        @(negedge clock);
        check("hold_proc_reset", proc_reset, 1'b1);
      end
      @(negedge clock);
      check("run_done", done, 1'b1);
      check("run_proc_reset", proc_reset, 1'b0);
      check("run_error", error, 1'b0);
      base = wr_count;
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clock);
      check("run_in_ready", in_ready, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      check("run_ignores_input", wr_count - base, 0);
      check("run_done_sticky", done, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    check("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] s;
    int n;

    q = '{32'h11, 32'h22, 32'h33};
    run_image(3, q, 32'h66, 0);
    run_image(3, q, 32'h67, 0);
    q = {};
    run_image(0, q, 32'h0, 0);
    run_image(0, q, 32'h5, 0);
    run_image(MAXN + 1, q, 32'h0, 0);
    run_image(MAXN + 1 + int'($urandom_range(1000, 0)), q, 32'h0, 1);
    q = '{32'hFFFF_FFFF, 32'h2};
    run_image(2, q, 32'h1, 3);

    // Reset in the middle of a 5-word image, then a fresh 1-word image.
    do_reset();
    send(32'd5, 1'b0, 0, 0);
    send(32'hDEAD_0000, 1'b1, 0, 0);
    send(32'hDEAD_0001, 1'b1, 1, 1);
    q = '{32'hAB};
    run_image(1, q, 32'hAB, 0);

    // Largest legal image.
    q = {};
    s = '0;
    for (int i = 0; i < MAXN; i++) begin
      q.push_back($urandom);
      s = s + q[i];
    end
    run_image(MAXN, q, s, 0);

    for (int k = 0; k < 12; k++) begin
      q = {};
      s = '0;
      n = int'($urandom_range(8, 0));
      for (int i = 0; i < n; i++) begin
        q.push_back($urandom);
        s = s + q[i];
      end
      if ($urandom_range(3, 0) == 0) s = s + DW'($urandom_range(100, 1));
      run_image(n, q, s, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
